// File: rtl/tdm_demux4_if.sv
// Bus interface for tdm_demux4: one TDM input stream in, four channel words out.
// The master modport is the stream source and consumer; the slave modport is the demux.
interface tdm_demux4_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_sync;
    logic [DATA_W-1:0]     in_data;
    logic [4*DATA_W-1:0]   out_data;
    logic [3:0]            out_valid;
    logic                  frame_done;
    logic                  locked;
    logic                  sync_err;

    modport master (
        output in_valid, in_sync, in_data,
        input  out_data, out_valid, frame_done, locked, sync_err
    );

    modport slave (
        input  in_valid, in_sync, in_data,
        output out_data, out_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 1-to-4 time-division demultiplexer.
// Words interleaved round-robin from four channels (slot 0 flagged by in_sync) are
// routed to per-channel holding registers packed as {ch3,ch2,ch1,ch0} on out_data.
// A two-state framer (HUNT/LOCKED) tracks the slot position and flags framing errors.
// Optional macro TDM_DEMUX_FRAME_BUF_EN: slot words collect in a shadow bank and all
// four channels update together when the frame completes.
module tdm_demux4 #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [1:0]               slot_q, slot_d;
    logic                     wr_en;
    logic [1:0]               wr_slot;
    logic                     frame_done_d;
    logic                     sync_err_d;
    logic                     frame_done_q;
    logic                     sync_err_q;
    logic [3:0]               out_valid_q;
    logic [3:0][DATA_W-1:0]   ch_q;

    // Framer: decide acceptance, target slot, next state and pulses for this word.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        slot_d       = slot_q;
        wr_en        = 1'b0;
        wr_slot      = 2'd0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.in_sync) begin
                        wr_en   = 1'b1;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.in_sync) begin
                        // A sync before slot 3 completed abandons the partial frame and
                        // restarts at slot 0 without dropping lock.
                        sync_err_d = (slot_q != 2'd0);
                        wr_en      = 1'b1;
                        slot_d     = 2'd1;
                    end else if (slot_q != 2'd0) begin
                        wr_en        = 1'b1;
                        wr_slot      = slot_q;
                        slot_d       = slot_q + 2'd1;
                        frame_done_d = (slot_q == 2'd3);
                    end else begin
                        // Slot 0 arrived without sync: alignment is lost, go hunting.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Framer state, slot counter and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

`ifdef TDM_DEMUX_FRAME_BUF_EN
    // Slots 0..2 wait in the shadow bank; slot 3 goes straight to the output.
    logic [2:0][DATA_W-1:0] shadow_q;

    // Shadow capture and atomic whole-frame update of the channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register banks are reset explicitly because their contents are
            // visible on out_data straight after reset and must read as zero.
            shadow_q    <= '0;
            ch_q        <= '0;
            out_valid_q <= 4'b0000;
        end else begin
            out_valid_q <= frame_done_d ? 4'b1111 : 4'b0000;
            if (wr_en && (wr_slot != 2'd3)) begin
                shadow_q[wr_slot] <= bus.in_data;
            end
            if (frame_done_d) begin
                ch_q <= {bus.in_data, shadow_q};
            end
        end
    end
`else
    // Per-slot update: each accepted word lands in its channel register directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the channel bank is reset explicitly because its contents are
            // visible on out_data straight after reset and must read as zero.
            ch_q        <= '0;
            out_valid_q <= 4'b0000;
        end else begin
            out_valid_q <= 4'b0000;
            if (wr_en) begin
                ch_q[wr_slot] <= bus.in_data;
                out_valid_q   <= 4'b0001 << wr_slot;
            end
        end
    end
`endif

    assign bus.out_data   = ch_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4. A queue-based frame model tracks the words of
// the frame in progress and predicts every output; directed scenarios add fixed
// expectations and a randomized run exercises gaps, early and missing syncs.
// Build with +define+TDM_DEMUX_FRAME_BUF_EN to check the frame-buffered variant.
module tb_tdm_demux4;

    logic clk;
    logic rst_n;

    tdm_demux4_if #(.DATA_W(8)) bus ();

    tdm_demux4 #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0][7:0] m_data;
    logic [3:0]      m_valid;
    logic            m_fd;
    logic            m_err;
    logic            m_locked;
    logic [7:0]      cur[$];

    logic [38:0] obs;
    assign obs = {bus.out_data, bus.out_valid, bus.frame_done, bus.locked, bus.sync_err};

    function automatic logic [38:0] exp_vec();
        return {m_data, m_valid, m_fd, m_locked, m_err};
    endfunction

    task automatic model_reset();
        m_data   = '0;
        m_valid  = 4'b0000;
        m_fd     = 1'b0;
        m_err    = 1'b0;
        m_locked = 1'b0;
        cur.delete();
    endtask

    // Frame rules: a synced word starts a frame, later words extend it, the fourth
    // word completes it; anything else is an error or a drop.
    task automatic model_step(input logic v, input logic s, input logic [7:0] d);
        int n;
        m_valid = 4'b0000;
        m_fd    = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            if (s) begin
                if (m_locked && cur.size() != 0) m_err = 1'b1;
                cur.delete();
                cur.push_back(d);
                m_locked = 1'b1;
`ifndef TDM_DEMUX_FRAME_BUF_EN
                m_data[0] = d;
                m_valid   = 4'b0001;
`endif
            end else if (m_locked) begin
                if (cur.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    cur.push_back(d);
                    n = cur.size();
`ifndef TDM_DEMUX_FRAME_BUF_EN
                    m_data[n-1] = d;
                    m_valid     = 4'b0001 << (n - 1);
`endif
                    if (n == 4) begin
                        m_fd = 1'b1;
`ifdef TDM_DEMUX_FRAME_BUF_EN
                        for (int k = 0; k < 4; k++) m_data[k] = cur[k];
                        m_valid = 4'b1111;
`endif
                        cur.delete();
                    end
                end
            end
        end
    endtask

    // Drive one cycle of input on the falling edge, sample just after the rising edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 39'd0) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", obs, 39'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_frame();
        logic [7:0] w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] want_ov;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, w[i]);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL clean_frame[%0d] got %h want %h", i, obs, exp_vec());
            end
`ifdef TDM_DEMUX_FRAME_BUF_EN
            want_ov = (i == 3) ? 4'b1111 : 4'b0000;
`else
            want_ov = 4'b0001 << i;
`endif
            n_vec++;
            if (bus.out_valid !== want_ov || bus.frame_done !== (i == 3)) begin
                n_err++;
                $display("FAIL clean_pulses[%0d] got ov=%b fd=%b want ov=%b fd=%b",
                         i, bus.out_valid, bus.frame_done, want_ov, i == 3);
            end
        end
        n_vec++;
        if (bus.out_data !== 32'h44332211 || bus.locked !== 1'b1) begin
            n_err++;
            $display("FAIL clean_final got data=%h locked=%b want 44332211/1",
                     bus.out_data, bus.locked);
        end
    endtask

    task automatic test_gap();
        logic       v[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] w[6] = '{8'h11, 8'h22, 8'hEE, 8'hEE, 8'h33, 8'h44};
        int fd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive(v[i], i == 0, w[i]);
            fd_cnt += int'(bus.frame_done);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL gap[%0d] got %h want %h", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (fd_cnt != 1 || bus.out_data !== 32'h44332211) begin
            n_err++;
            $display("FAIL gap_final got fd_cnt=%0d data=%h want 1/44332211",
                     fd_cnt, bus.out_data);
        end
    endtask

    task automatic test_hunt();
        logic [7:0] w[6] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i == 2, w[i]);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL hunt[%0d] got %h want %h", i, obs, exp_vec());
            end
            n_vec++;
            if (bus.locked !== (i >= 2)) begin
                n_err++;
                $display("FAIL hunt_locked[%0d] got %b want %b", i, bus.locked, i >= 2);
            end
        end
        n_vec++;
        if (bus.out_data !== 32'h04030201) begin
            n_err++;
            $display("FAIL hunt_final got %h want 04030201", bus.out_data);
        end
    endtask

    task automatic test_early_sync();
        logic       s[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] w[6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, s[i], w[i]);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL early[%0d] got %h want %h", i, obs, exp_vec());
            end
            if (i == 2) begin
                n_vec++;
`ifdef TDM_DEMUX_FRAME_BUF_EN
                if (bus.sync_err !== 1'b1 || bus.frame_done !== 1'b0 ||
                    bus.out_data !== 32'h04030201) begin
`else
                if (bus.sync_err !== 1'b1 || bus.frame_done !== 1'b0 ||
                    bus.out_data[15:0] !== 16'h2030) begin
`endif
                    n_err++;
                    $display("FAIL early_sync_err got err=%b fd=%b data=%h",
                             bus.sync_err, bus.frame_done, bus.out_data);
                end
            end
        end
        n_vec++;
        if (bus.frame_done !== 1'b1 || bus.out_data !== 32'h60504030) begin
            n_err++;
            $display("FAIL early_final got fd=%b data=%h want 1/60504030",
                     bus.frame_done, bus.out_data);
        end
    endtask

    task automatic test_missing_sync();
        drive(1'b1, 1'b0, 8'h55);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL missing got %h want %h", obs, exp_vec());
        end
        n_vec++;
        if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.out_valid !== 4'b0000 ||
            bus.out_data !== 32'h60504030) begin
            n_err++;
            $display("FAIL missing_fixed got err=%b locked=%b ov=%b data=%h",
                     bus.sync_err, bus.locked, bus.out_valid, bus.out_data);
        end
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (bus.sync_err !== 1'b0) begin
            n_err++;
            $display("FAIL missing_pulse_width got %b want 0", bus.sync_err);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 8'hA1);
        drive(1'b1, 1'b0, 8'hA2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs !== 39'd0) begin
            n_err++;
            $display("FAIL async_reset got %h want %h", obs, 39'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL post_reset_hunt got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic v;
        logic s;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (cur.size() == 0) s = ($urandom_range(0, 7) != 0);
            else                 s = ($urandom_range(0, 9) == 0);
            drive(v, s, 8'($urandom));
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d] got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_gap();
        test_hunt();
        test_early_sync();
        test_missing_sync();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
